// File: rtl/rx_frame_sync.sv
// rx_frame_sync: RIFL RX frame-alignment controller.
// Marks the first beat of each frame (o_data_sof) for the RX width converter.
// Hunts for alignment using per-frame CRC results, slipping one beat at a
// time, and tracks lock with HUNT / VERIFY / LOCKED states.
// Optional macro RIFL_RX_FSYNC_STATS_EN enables the saturating statistics
// counters; without it both statistics outputs are tied to zero.
module rx_frame_sync #(
  parameter int DWIDTH         = 64,
  parameter int FRAME_WIDTH    = 256,
  parameter int LOCK_GOOD_CNT  = 8,
  parameter int UNLOCK_BAD_CNT = 4,
  parameter int BLANK_FRAMES   = 2,
  parameter int STAT_WIDTH     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_beat_valid,
  input  logic                  i_crc_valid,
  input  logic                  i_crc_good,
  output logic                  o_data_sof,
  output logic                  o_slip_req,
  output logic                  o_frame_lock,
  output logic [1:0]            o_sync_state,
  output logic [STAT_WIDTH-1:0] o_crc_err_cnt,
  output logic [STAT_WIDTH-1:0] o_lock_loss_cnt
);

  localparam int RATIO   = FRAME_WIDTH / DWIDTH;
  localparam int BCNT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int GOOD_W  = $clog2(LOCK_GOOD_CNT + 1);
  localparam int BAD_W   = $clog2(UNLOCK_BAD_CNT + 1);
  localparam int BLANK_W = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_frame_lock;
  logic [BCNT_W-1:0]  r_bcnt;
  logic [GOOD_W-1:0]  r_good_cnt;
  logic [BAD_W-1:0]   r_bad_cnt;
  logic [BLANK_W-1:0] r_blank_cnt;
  logic               r_slip_pend;

  logic               w_slip_exec;
  logic               w_eval;
  logic               w_decide;
  logic [GOOD_W-1:0]  w_good_inc;
  logic [BAD_W-1:0]   w_bad_inc;
  logic               w_bad_limit;

  // Slip execution, CRC qualification and the slip decision for this cycle.
  always_comb begin
    w_slip_exec = 1'b0;
    w_eval      = 1'b0;
    w_decide    = 1'b0;
    w_good_inc  = r_good_cnt + GOOD_W'(1);
    w_bad_inc   = r_bad_cnt + BAD_W'(1);
    w_bad_limit = (w_bad_inc == BAD_W'(UNLOCK_BAD_CNT));
    if (RATIO == 1) begin
      // Upstream bitslip handles alignment: pulse the cycle after deciding.
      w_slip_exec = r_slip_pend;
    end else begin
      // The slip waits for a valid beat so the held beat is a real one.
      w_slip_exec = r_slip_pend & i_beat_valid;
    end
    w_eval = i_crc_valid & (r_blank_cnt == BLANK_W'(0));
    if (w_eval && !i_crc_good) begin
      case (r_state)
        ST_HUNT:   w_decide = 1'b1;
        ST_VERIFY: w_decide = 1'b1;
        ST_LOCKED: w_decide = w_bad_limit;
        default:   w_decide = 1'b1;
      endcase
    end else begin
      w_decide = 1'b0;
    end
  end

  assign o_data_sof   = i_rst_n & i_beat_valid & (r_bcnt == BCNT_W'(0));
  assign o_slip_req   = w_slip_exec;
  assign o_frame_lock = r_frame_lock;
  assign o_sync_state = r_state;

  // Beat position within the frame; a slip holds it for one beat.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_bcnt <= BCNT_W'(0);
    end else if (RATIO == 1) begin
      r_bcnt <= BCNT_W'(0);
    end else if (i_beat_valid && !w_slip_exec) begin
      r_bcnt <= r_bcnt + BCNT_W'(1);
    end else begin
      r_bcnt <= r_bcnt;
    end
  end

  // Pending slip: a decision while one is already pending merges into it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_slip_pend <= 1'b0;
    end else if (w_slip_exec) begin
      r_slip_pend <= 1'b0;
    end else begin
      r_slip_pend <= r_slip_pend | w_decide;
    end
  end

  // Blanking of CRC results still in flight from the old alignment.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_blank_cnt <= BLANK_W'(0);
    end else if (w_slip_exec) begin
      r_blank_cnt <= BLANK_W'(BLANK_FRAMES);
    end else if (i_crc_valid && (r_blank_cnt != BLANK_W'(0))) begin
      r_blank_cnt <= r_blank_cnt - BLANK_W'(1);
    end else begin
      r_blank_cnt <= r_blank_cnt;
    end
  end

  // Alignment state machine, advanced only by non-blanked CRC results.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_HUNT;
      r_frame_lock <= 1'b0;
      r_good_cnt   <= GOOD_W'(0);
      r_bad_cnt    <= BAD_W'(0);
    end else if (w_eval) begin
      case (r_state)
        ST_HUNT: begin
          if (i_crc_good) begin
            if (LOCK_GOOD_CNT == 1) begin
              r_state      <= ST_LOCKED;
              r_frame_lock <= 1'b1;
              r_good_cnt   <= GOOD_W'(0);
              r_bad_cnt    <= BAD_W'(0);
            end else begin
              r_state    <= ST_VERIFY;
              r_good_cnt <= GOOD_W'(1);
            end
          end else begin
            r_state <= ST_HUNT;
          end
        end
        ST_VERIFY: begin
          if (i_crc_good) begin
            if (w_good_inc == GOOD_W'(LOCK_GOOD_CNT)) begin
              r_state      <= ST_LOCKED;
              r_frame_lock <= 1'b1;
              r_good_cnt   <= GOOD_W'(0);
              r_bad_cnt    <= BAD_W'(0);
            end else begin
              r_good_cnt <= w_good_inc;
            end
          end else begin
            r_state    <= ST_HUNT;
            r_good_cnt <= GOOD_W'(0);
          end
        end
        ST_LOCKED: begin
          if (i_crc_good) begin
            r_bad_cnt <= BAD_W'(0);
          end else if (w_bad_limit) begin
            r_state      <= ST_HUNT;
            r_frame_lock <= 1'b0;
            r_bad_cnt    <= BAD_W'(0);
          end else begin
            r_bad_cnt <= w_bad_inc;
          end
        end
        default: begin
          r_state      <= ST_HUNT;
          r_frame_lock <= 1'b0;
          r_good_cnt   <= GOOD_W'(0);
          r_bad_cnt    <= BAD_W'(0);
        end
      endcase
    end else begin
      r_state <= r_state;
    end
  end

`ifdef RIFL_RX_FSYNC_STATS_EN
  logic [STAT_WIDTH-1:0] r_crc_err_cnt;
  logic [STAT_WIDTH-1:0] r_lock_loss_cnt;
  logic                  w_err_evt;
  logic                  w_loss_evt;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + STAT_WIDTH'(1);
    end
  endfunction

  assign w_err_evt  = w_eval & ~i_crc_good;
  assign w_loss_evt = w_err_evt & (r_state == ST_LOCKED) & w_bad_limit;

  // Saturating statistics for bad CRCs and lock losses.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_crc_err_cnt   <= STAT_WIDTH'(0);
      r_lock_loss_cnt <= STAT_WIDTH'(0);
    end else begin
      if (w_err_evt) begin
        r_crc_err_cnt <= sat_inc(r_crc_err_cnt);
      end else begin
        r_crc_err_cnt <= r_crc_err_cnt;
      end
      if (w_loss_evt) begin
        r_lock_loss_cnt <= sat_inc(r_lock_loss_cnt);
      end else begin
        r_lock_loss_cnt <= r_lock_loss_cnt;
      end
    end
  end

  assign o_crc_err_cnt   = r_crc_err_cnt;
  assign o_lock_loss_cnt = r_lock_loss_cnt;
`else
  assign o_crc_err_cnt   = STAT_WIDTH'(0);
  assign o_lock_loss_cnt = STAT_WIDTH'(0);
`endif

endmodule

// File: tb/tb_rx_frame_sync.sv
// Self-checking bench for rx_frame_sync: directed scenarios with literal
// expectations plus a randomized run against a behavioural frame model.
module tb_rx_frame_sync;
  localparam int DW       = 64;
  localparam int FW       = 256;
  localparam int RATIO    = FW / DW;
  localparam int LOCK_N   = 8;
  localparam int UNLOCK_N = 4;
  localparam int BLANK_N  = 2;
  localparam int SW       = 16;
  localparam int MAXS     = (1 << SW) - 1;
`ifdef RIFL_RX_FSYNC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, beat_valid, crc_valid, crc_good;
  logic data_sof, slip_req, frame_lock;
  logic [1:0] sync_state;
  logic [SW-1:0] crc_err_cnt, lock_loss_cnt;

  always #5 clk = ~clk;

  rx_frame_sync #(
    .DWIDTH(DW), .FRAME_WIDTH(FW), .LOCK_GOOD_CNT(LOCK_N),
    .UNLOCK_BAD_CNT(UNLOCK_N), .BLANK_FRAMES(BLANK_N), .STAT_WIDTH(SW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_beat_valid(beat_valid),
    .i_crc_valid(crc_valid), .i_crc_good(crc_good),
    .o_data_sof(data_sof), .o_slip_req(slip_req), .o_frame_lock(frame_lock),
    .o_sync_state(sync_state), .o_crc_err_cnt(crc_err_cnt),
    .o_lock_loss_cnt(lock_loss_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: position in frame, alignment state, counters.
  bit m_valid = 1'b0;
  int m_pos = 0, m_state = 0, m_good = 0, m_bad = 0, m_blank = 0;
  int m_err = 0, m_loss = 0, m_slips = 0;
  bit m_pend = 1'b0;

  // Model update on each rising edge from the inputs of the ending cycle.
  always @(posedge clk) begin : model_upd
    bit ex, ev, dec;
    int ns, ng, nb, ne, nl, nbl, np;
    if (!rst_n) begin
      m_valid <= 1'b1;
      m_pos <= 0; m_state <= 0; m_good <= 0; m_bad <= 0; m_blank <= 0;
      m_err <= 0; m_loss <= 0; m_pend <= 1'b0;
    end else begin
      ex  = m_pend && (RATIO == 1 || beat_valid);
      ev  = crc_valid && (m_blank == 0);
      dec = 1'b0;
      ns = m_state; ng = m_good; nb = m_bad; ne = m_err; nl = m_loss;
      if (ev) begin
        if (!crc_good && ne < MAXS) ne = ne + 1;
        if (m_state == 0) begin
          if (crc_good) begin
            if (LOCK_N == 1) begin ns = 2; nb = 0; end
            else begin ns = 1; ng = 1; end
          end else dec = 1'b1;
        end else if (m_state == 1) begin
          if (crc_good) begin
            ng = m_good + 1;
            if (ng >= LOCK_N) begin ns = 2; nb = 0; end
          end else begin ns = 0; ng = 0; dec = 1'b1; end
        end else begin
          if (crc_good) nb = 0;
          else begin
            nb = m_bad + 1;
            if (nb >= UNLOCK_N) begin
              ns = 0; nb = 0; dec = 1'b1;
              if (nl < MAXS) nl = nl + 1;
            end
          end
        end
      end
      if (ex) nbl = BLANK_N;
      else if (crc_valid && m_blank > 0) nbl = m_blank - 1;
      else nbl = m_blank;
      np = (beat_valid && !(ex && RATIO > 1)) ? (m_pos + 1) % RATIO : m_pos;
      m_state <= ns; m_good <= ng; m_bad <= nb; m_err <= ne; m_loss <= nl;
      m_blank <= nbl; m_pos <= np;
      m_pend  <= ex ? 1'b0 : (m_pend || dec);
      m_slips <= m_slips + (ex ? 1 : 0);
    end
  end

  int q_gap[$];
  int beat_idx = 0, last_sof = 0;
  bit have_last = 1'b0;

  // Per-cycle comparison against the model, plus frame-gap recording.
  always @(negedge clk) begin
    if (m_valid) begin
      check("data_sof", data_sof, rst_n && beat_valid && (m_pos == 0));
      check("slip_req", slip_req, m_pend && (RATIO == 1 || beat_valid));
      check("frame_lock", frame_lock, m_state == 2);
      check("sync_state", sync_state, m_state);
      check("crc_err_cnt", crc_err_cnt, STATS ? m_err : 0);
      check("lock_loss_cnt", lock_loss_cnt, STATS ? m_loss : 0);
    end
    if (!rst_n) have_last = 1'b0;
    else if (beat_valid) begin
      beat_idx++;
      if (data_sof) begin
        if (have_last) q_gap.push_back(beat_idx - last_sof);
        last_sof  = beat_idx;
        have_last = 1'b1;
      end
    end
  end

  task automatic drive(input bit r, input bit bv, input bit cv, input bit g);
    @(posedge clk);
    #1;
    rst_n = r; beat_valid = bv; crc_valid = cv; crc_good = g;
    #3;
  endtask

  task automatic crc_pulse(input bit g);
    drive(1'b1, 1'b1, 1'b1, g);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // Advance until the current beat is a frame start.
  task automatic align_sof(input string nm);
    bit found = 1'b0;
    for (int k = 0; k < 2 * RATIO + 2 && !found; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      if (data_sof) found = 1'b1;
    end
    check({nm, "_sof_found"}, found, 1'b1);
  endtask

  task automatic gap_check(input string nm);
    int n5 = 0, nbad = 0;
    foreach (q_gap[i]) begin
      if (q_gap[i] == RATIO + 1) n5++;
      else if (q_gap[i] != RATIO) nbad++;
    end
    check({nm, "_one_long_gap"}, n5, 1);
    check({nm, "_other_gaps"}, nbad, 0);
  endtask

  initial begin
    int nslip;
    int target;
    bit aligned, g;
    rst_n = 1'b0; beat_valid = 1'b0; crc_valid = 1'b0; crc_good = 1'b0;

    // Reset with beats present: no SOF while rst_n is low.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      if (k > 0) begin
        check("rst_sof", data_sof, 1'b0);
        check("rst_state", sync_state, 2'd0);
        check("rst_lock", frame_lock, 1'b0);
        check("rst_slip", slip_req, 1'b0);
      end
    end
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      check("sof_pattern", data_sof, (k % 4) == 0);
      check("hunt_state", sync_state, 2'd0);
    end

    // Eight good CRCs in HUNT lead to LOCKED.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      check("verify_before", sync_state, (i == 0) ? 2'd0 : 2'd1);
      check("lock_before", frame_lock, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      check("verify_after", sync_state, (i == 7) ? 2'd2 : 2'd1);
      check("lock_after", frame_lock, i == 7);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
    end
    check("lock_err_cnt", crc_err_cnt, 0);

    // LOCKED: bad,bad,good,bad,bad,bad,bad drops lock on the last one.
    nslip = 0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 1'b1, i == 2);
      nslip += slip_req;
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      nslip += slip_req;
      check("unlock_state", sync_state, (i < 6) ? 2'd2 : 2'd0);
      check("unlock_lock", frame_lock, i < 6);
      if (i == 6) check("unlock_slip_now", slip_req, 1'b1);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      nslip += slip_req;
    end
    check("unlock_slip_count", nslip, 1);
    check("unlock_err_cnt", crc_err_cnt, STATS ? 6 : 0);
    check("unlock_loss_cnt", lock_loss_cnt, STATS ? 1 : 0);

    // Two blanked CRCs are ignored even though they are good.
    for (int i = 0; i < 2; i++) begin
      crc_pulse(1'b1);
      check("blank_ignored", sync_state, 2'd0);
    end

    // HUNT bad CRC: one slip, one 5-beat frame.
    align_sof("hunt");
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    q_gap.delete();
    nslip = 0;
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      nslip += slip_req;
    end
    check("hunt_slip_count", nslip, 1);
    gap_check("hunt");
    check("hunt_err_cnt", crc_err_cnt, STATS ? 7 : 0);
    for (int i = 0; i < 2; i++) begin
      crc_pulse(1'b1);
      check("blank2_ignored", sync_state, 2'd0);
    end
    crc_pulse(1'b1);
    check("after_blank_verify", sync_state, 2'd1);

    // Slip pending across three idle cycles.
    align_sof("stall");
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    q_gap.delete();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      check("stall_no_slip", slip_req, 1'b0);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("stall_slip", slip_req, 1'b1);
    for (int k = 0; k < 15; k++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    gap_check("stall");
    check("stall_state", sync_state, 2'd0);
    check("stall_err_cnt", crc_err_cnt, STATS ? 8 : 0);

    // Relock, then reset while LOCKED at beat position 2.
    for (int i = 0; i < 10; i++) crc_pulse(1'b1);
    check("relock", frame_lock, 1'b1);
    align_sof("prerst");
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("midrst_sof", data_sof, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("post_rst_sof", data_sof, 1'b0);
    check("post_rst_slip", slip_req, 1'b0);
    check("post_rst_lock", frame_lock, 1'b0);
    check("post_rst_state", sync_state, 2'd0);
    check("post_rst_err", crc_err_cnt, 0);
    check("post_rst_loss", lock_loss_cnt, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("post_rst_first_sof", data_sof, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("post_rst_second", data_sof, 1'b0);

    // Randomized run: CRC mostly good only at one slip phase.
    target = $urandom_range(0, RATIO - 1);
    for (int c = 0; c < 5000; c++) begin
      aligned = ((m_slips % RATIO) == target);
      g = aligned ? ($urandom % 16 != 0) : ($urandom % 8 == 0);
      drive(($urandom % 700) != 0, ($urandom % 4) != 0, ($urandom % 3) == 0, g);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
